// File: rtl/rgb_mixer_pkg.sv
// Shared types and saturating arithmetic for the RGB mixer channel controller.
package rgb_mixer_pkg;

  localparam int unsigned COLOR_W = 8;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    WAIT_REL
  } btn_state_e;

  // ch + delta*step evaluated in 16-bit signed, clamped into 0..255.
  function automatic logic [COLOR_W-1:0] sat_add(input logic [COLOR_W-1:0] ch,
                                                 input logic signed [7:0] delta,
                                                 input logic [7:0] step);
    logic signed [15:0] sum;
    sum = $signed({8'd0, ch}) + 16'(delta) * $signed({8'd0, step});
    if (sum < 16'sd0) begin
      return '0;
    end else if (sum > 16'sd255) begin
      return '1;
    end else begin
      return sum[COLOR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for the push-button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic [CntW-1:0] stable_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      btn_db       <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      // Count consecutive cycles the synchronised level disagrees with btn_db.
      if (sync2_q != btn_db) begin
        if (stable_cnt_q == CntMax) begin
          btn_db       <= sync2_q;
          stable_cnt_q <= '0;
        end else begin
          stable_cnt_q <= stable_cnt_q + 1'b1;
        end
      end else begin
        stable_cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/rgb_channel_controller.sv
// Routes encoder deltas to the selected RGB channel with saturation; the button
// cycles the selection on a short press and clears the channel on a long press.
module rgb_channel_controller
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned STEP            = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] count,
  input  logic               btn,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [1:0]         sel,
  output logic               upd
);

  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);
  localparam logic [7:0] StepVal = 8'(STEP);

  logic               btn_db;
  logic               db_prev_q;
  btn_state_e         state_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [COLOR_W-1:0] count_prev_q;
  channel_e           sel_q;
  channel_e           sel_next;
  logic signed [7:0]  delta;
  logic               db_rise, db_fall, short_ev, long_ev;
  logic [COLOR_W-1:0] cur, nxt, wr_val;
  logic               wr_en;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .btn_db(btn_db)
  );

  // A raw jump of 128 lands on -128 through the signed reinterpretation.
  assign delta    = $signed(count - count_prev_q);
  assign db_rise  = btn_db & ~db_prev_q;
  assign db_fall  = ~btn_db & db_prev_q;
  assign short_ev = (state_q == HELD) && db_fall;
  assign long_ev  = (state_q == HELD) && !db_fall && (hold_cnt_q == HoldMax);
  assign sel      = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      db_prev_q  <= 1'b0;
    end else begin
      db_prev_q <= btn_db;
      case (state_q)
        IDLE: begin
          if (db_rise) begin
            state_q    <= HELD;
            hold_cnt_q <= '0;
          end
        end
        HELD: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (db_fall) begin
            state_q <= IDLE;
          end else if (hold_cnt_q == HoldMax) begin
            state_q <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (db_fall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (sel_q)
      CH_G:    cur = green;
      CH_B:    cur = blue;
      default: cur = red;
    endcase
    case (sel_q)
      CH_R:    sel_next = CH_G;
      CH_G:    sel_next = CH_B;
      default: sel_next = CH_R;
    endcase
    nxt = sat_add(cur, delta, StepVal);
    // A long press overrides any delta arriving on the same edge.
    if (long_ev) begin
      wr_en  = (cur != '0);
      wr_val = '0;
    end else begin
      wr_en  = (nxt != cur);
      wr_val = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_prev_q <= '0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      sel_q        <= CH_R;
      upd          <= 1'b0;
    end else begin
      count_prev_q <= count;
      upd          <= wr_en;
      if (wr_en) begin
        case (sel_q)
          CH_G:    green <= wr_val;
          CH_B:    blue  <= wr_val;
          default: red   <= wr_val;
        endcase
      end
      if (short_ev) sel_q <= sel_next;
    end
  end

endmodule
